// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and counts retired instructions.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP with illegal=1 instead of acting as a NOP.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int IMM_SRC_W  = 2,
    parameter int RET_CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic [RET_CNT_W-1:0]  instr_retired,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(5);

    state_t state, state_nxt;
    logic   retire;

    function automatic logic [ALU_CTRL_W-1:0] alu_dec(input logic [2:0] f3,
                                                      input logic is_r,
                                                      input logic f7b5);
        case (f3)
            3'b000:  alu_dec = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_RTYPE:          state_nxt = S_EXECR;
                    OP_ITYPE:          state_nxt = S_EXECI;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_nxt = S_TRAP;
`else
                    default:           state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECR,
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_FETCH;
        endcase
    end

    // An illegal-opcode NOP returns from DECODE, so it never counts as retired.
    assign retire = (state_nxt == S_FETCH) &&
                    (state == S_MEMWB || state == S_MEMWRITE ||
                     state == S_ALUWB || state == S_BRANCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            instr_retired <= '0;
        end else begin
            state <= state_nxt;
            if (retire) instr_retired <= instr_retired + RET_CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

    // Outputs are gated by rst_n so a reset mid-access drops mem_req at once.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        imm_src     = IMM_SRC_W'(0);
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = IMM_SRC_W'(2);
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_LOAD) ? IMM_SRC_W'(0) : IMM_SRC_W'(1);
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = alu_dec(funct3, 1'b1, funct7b5);
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = alu_dec(funct3, 1'b0, funct7b5);
                end
                S_ALUWB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a   = 2'b10;
                    alu_control = ALU_SUB;
                    case (funct3)
                        3'b000:  pc_write = zero;
                        3'b001:  pc_write = ~zero;
                        default: pc_write = 1'b0;
                    endcase
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (4-bit retire counter so wrap is reachable).
// Honors ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic [3:0] instr_retired;
    logic       illegal;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    multicycle_control_unit #(.ALU_CTRL_W(3), .IMM_SRC_W(2), .RET_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .instr_retired(instr_retired),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,result_src,alu_src_a,alu_src_b,alu_control,imm_src}
    logic [16:0] sig;
    assign sig = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control, imm_src};

    localparam logic [16:0] SIG_IDLE   = 17'b000000_00_00_00_000_00;
    localparam logic [16:0] SIG_FETCH  = 17'b100110_10_00_10_000_00;
    localparam logic [16:0] SIG_FWAIT  = 17'b100000_10_00_10_000_00;
    localparam logic [16:0] SIG_DECODE = 17'b000000_00_01_01_000_10;
    localparam logic [16:0] SIG_ADR_LD = 17'b000000_00_10_01_000_00;
    localparam logic [16:0] SIG_ADR_ST = 17'b000000_00_10_01_000_01;
    localparam logic [16:0] SIG_MRD    = 17'b101000_00_00_00_000_00;
    localparam logic [16:0] SIG_MWB    = 17'b000001_01_00_00_000_00;
    localparam logic [16:0] SIG_MWR    = 17'b111000_00_00_00_000_00;
    localparam logic [16:0] SIG_ALUWB  = 17'b000001_00_00_00_000_00;
    localparam logic [16:0] SIG_BR_TK  = 17'b000010_00_10_00_001_00;
    localparam logic [16:0] SIG_BR_NT  = 17'b000000_00_10_00_001_00;
    localparam logic [16:0] SIG_JAL    = 17'b000010_00_01_10_000_00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input logic [16:0] exp);
        #1;
        check(tag, {15'd0, sig}, {15'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
        expect_sig("fetch", SIG_FETCH);
        tick();
        expect_sig("decode", SIG_DECODE);
        tick();
    endtask

    // EXECR/EXECI followed by ALUWB, then back in FETCH.
    task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [16:0] exp_exec);
        fetch_decode(o, f3, f7);
        expect_sig(tag, exp_exec);
        tick();
        expect_sig("aluwb", SIG_ALUWB);
        tick();
        exp_cnt++;
        check("cnt_alu", {28'd0, instr_retired}, 32'(exp_cnt % 16));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #11;
        check("rst_sig", {15'd0, sig}, 32'd0);
        check("rst_cnt", {28'd0, instr_retired}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        // lw with memory always ready
        fetch_decode(7'b0000011, 3'b010, 1'b0);
        expect_sig("memadr_ld", SIG_ADR_LD); tick();
        expect_sig("memread", SIG_MRD); tick();
        expect_sig("memwb", SIG_MWB); tick();
        exp_cnt++;
        check("cnt_lw", {28'd0, instr_retired}, 32'd1);

        // sw: fetch waits 2 cycles, MEMWRITE waits 3 cycles
        op = 7'b0100011; funct3 = 3'b010; mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin expect_sig("fetch_wait", SIG_FWAIT); tick(); end
        mem_ready = 1'b1;
        expect_sig("fetch_sw", SIG_FETCH); tick();
        expect_sig("decode_sw", SIG_DECODE); tick();
        expect_sig("memadr_st", SIG_ADR_ST); tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_sig("memwrite_wait", SIG_MWR);
            check("cnt_sw_wait", {28'd0, instr_retired}, 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        expect_sig("memwrite_done", SIG_MWR); tick();
        exp_cnt++;
        check("cnt_sw", {28'd0, instr_retired}, 32'd2);

        alu_instr("execr_sub",  7'b0110011, 3'b000, 1'b1, 17'b000000_00_10_00_001_00);
        alu_instr("execi_add",  7'b0010011, 3'b000, 1'b1, 17'b000000_00_10_01_000_00);
        alu_instr("execr_and",  7'b0110011, 3'b111, 1'b0, 17'b000000_00_10_00_010_00);
        alu_instr("execi_slt",  7'b0010011, 3'b010, 1'b0, 17'b000000_00_10_01_101_00);
        alu_instr("execr_or",   7'b0110011, 3'b110, 1'b1, 17'b000000_00_10_00_011_00);

        // beq taken, bne not taken (zero=1 both)
        fetch_decode(7'b1100011, 3'b000, 1'b0);
        zero = 1'b1;
        expect_sig("beq_z1", SIG_BR_TK); tick();
        exp_cnt++;
        check("cnt_beq", {28'd0, instr_retired}, 32'(exp_cnt));
        fetch_decode(7'b1100011, 3'b001, 1'b0);
        expect_sig("bne_z1", SIG_BR_NT); tick();
        exp_cnt++;
        check("cnt_bne", {28'd0, instr_retired}, 32'(exp_cnt));
        zero = 1'b0;

        // jal retires once, through ALUWB
        fetch_decode(7'b1101111, 3'b000, 1'b0);
        expect_sig("jal", SIG_JAL); tick();
        expect_sig("jal_wb", SIG_ALUWB); tick();
        exp_cnt++;
        check("cnt_jal", {28'd0, instr_retired}, 32'd10);

        // adds until 16 retired -> 4-bit counter wraps to 0
        while (exp_cnt < 16)
            alu_instr("execi_loop", 7'b0010011, 3'b000, 1'b0, 17'b000000_00_10_01_000_00);
        check("cnt_wrap", {28'd0, instr_retired}, 32'd0);

        // illegal opcode
        fetch_decode(7'b1111111, 3'b000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            expect_sig("trap_sig", SIG_IDLE);
            check("trap_illegal", {31'd0, illegal}, 32'd1);
            tick();
        end
        check("trap_cnt", {28'd0, instr_retired}, 32'd0);
        rst_n = 1'b0; #1;
        check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;
        expect_sig("trap_rst_fetch", SIG_FETCH);
        op = 7'b0010011;
        tick();
        expect_sig("trap_rst_decode", SIG_DECODE);
        tick(); tick(); tick();
`else
        expect_sig("nop_fetch", SIG_FETCH);
        check("nop_illegal", {31'd0, illegal}, 32'd0);
        check("nop_cnt", {28'd0, instr_retired}, 32'd0);
        tick();
        expect_sig("nop_decode2", SIG_DECODE);
        op = 7'b0010011;
        tick(); tick(); tick();
`endif
        // now back in FETCH (counter either 0 or 1); reset during a stalled load read
        fetch_decode(7'b0000011, 3'b010, 1'b0);
        expect_sig("mid_memadr", SIG_ADR_LD); tick();
        mem_ready = 1'b0;
        expect_sig("mid_memread", SIG_MRD);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sig", {15'd0, sig}, 32'd0);
        check("mid_rst_cnt", {28'd0, instr_retired}, 32'd0);
        tick();
        rst_n = 1'b1;
        expect_sig("mid_rst_fetch", SIG_FWAIT);
        tick();
        check("mid_rst_cnt2", {28'd0, instr_retired}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
